// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
// The stage drives the request side; the unit returns busy/done and the registered result.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] Result;

  modport master (
    output start, op, SrcA, SrcB,
    input  busy, done, Result
  );

  modport slave (
    input  start, op, SrcA, SrcB,
    output busy, done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and restoring divider on
// operand magnitudes, followed by one sign-correction cycle. One operation in flight at a time.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic         accept, div_zero, dz_pend;
  logic         sign_a, sign_b;
  logic [W-1:0] mag_a, mag_b;

  logic [2:0]    op_q;
  logic          neg_q, neg_r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  opnd;
  logic [2*W-1:0] prod, prod_next, prod_fix;
  logic [W-1:0]  rem, quot, quot_fix, rem_fix, dz_val, fix_val;
  logic [W:0]    mul_sum, rem_shift, rem_diff;

  // MULH/DIV/REM treat both operands as signed; MULHSU only rs1.
  assign sign_a = bus.SrcA[W-1] && (bus.op inside {3'b001, 3'b010, 3'b100, 3'b110});
  assign sign_b = bus.SrcB[W-1] && (bus.op inside {3'b001, 3'b100, 3'b110});
  assign mag_a  = sign_a ? -bus.SrcA : bus.SrcA;
  assign mag_b  = sign_b ? -bus.SrcB : bus.SrcB;

  assign div_zero = bus.op[2] && (bus.SrcB == '0);
  assign accept   = bus.start && !dz_pend && (state == IDLE || state == DONE);

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (dz_pend)                   state_next = DONE;
        else if (accept && !div_zero) state_next = CALC;
      end
      CALC:    if (cnt == CW'(W - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of each algorithm. The remainder always stays below the divisor, so it
  // is stored in W bits; the trial subtract runs W+1 wide and its MSB is the borrow.
  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : '0);
    prod_next = {mul_sum, prod[W-1:1]};
    rem_shift = {rem, quot[W-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
  end

  always_comb begin
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -quot : quot;
    rem_fix  = neg_r ? -rem  : rem;
    fix_val  = '0;
    case (op_q)
      3'b000:                 fix_val = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_val = quot_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // Control and output registers. A divide by zero spends one non-busy cycle in IDLE with
  // dz_pend set, so its result appears one edge after acceptance.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dz_pend    <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.Result <= '0;
    end else begin
      state    <= state_next;
      dz_pend  <= accept && div_zero;
      bus.busy <= (state_next == CALC) || (state_next == FIX);
      bus.done <= (state_next == DONE);
      if (state == FIX)  bus.Result <= fix_val;
      else if (dz_pend)  bus.Result <= dz_val;
    end
  end

  // NOTE: the datapath has no reset; every field is loaded on acceptance before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.op;
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      opnd   <= bus.op[2] ? mag_b : mag_a;
      prod   <= {{W{1'b0}}, mag_b};
      rem    <= '0;
      quot   <= mag_a;
      cnt    <= '0;
      dz_val <= bus.op[1] ? bus.SrcA : '1;
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (op_q[2]) begin
        if (!rem_diff[W]) begin
          rem  <= rem_diff[W-1:0];
          quot <= {quot[W-2:0], 1'b1};
        end else begin
          rem  <= rem_shift[W-1:0];
          quot <= {quot[W-2:0], 1'b0};
        end
      end else begin
        prod <= prod_next;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued when a request is driven and
// compared, with latency, whenever the unit pulses done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(W)) bus ();
  muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_done   = 0;

  logic [31:0] q_exp[$];
  int          q_edge[$];
  int          q_lat[$];
  string       q_tag[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    p   = '0;
    case (o)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0)   r = '1;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0)   r = a;
        else if (ovf) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    logic [31:0] e_exp;
    int          e_edge, e_lat;
    string       e_tag;
    if (bus.done) begin
      n_done++;
      if (q_exp.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        e_exp  = q_exp.pop_front();
        e_edge = q_edge.pop_front();
        e_lat  = q_lat.pop_front();
        e_tag  = q_tag.pop_front();
        check(e_tag, bus.Result, e_exp);
        check({e_tag, "_lat"}, 32'(cyc - e_edge), 32'(e_lat));
      end
    end
  end

  // Called at a falling edge; the request is sampled on the next rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    bus.start = 1'b1;
    bus.op    = o;
    bus.SrcA  = a;
    bus.SrcB  = b;
    q_exp.push_back(exp);
    q_edge.push_back(cyc + 1);
    q_lat.push_back((o[2] && b == 0) ? 1 : W + 1);
    q_tag.push_back(tag);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    check({tag, "_timeout"}, 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    @(negedge clk);
    issue(o, a, b, exp, tag);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_on"}, 32'(bus.busy), (o[2] && b == 0) ? 32'd0 : 32'd1);
    wait_done(tag);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int          base;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    bus.start = 1'b0;
    bus.op    = '0;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_result", bus.Result,    32'd0);
    rst = 1'b0;

    run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    run_op(3'b011, 32'd7,        32'hFFFF_FFFD, 32'h0000_0006, "mulhu");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, "divu_zero");
    run_op(3'b110, 32'd5,        32'd0,         32'd5,         "rem_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem");
    run_op(3'b101, 32'd100,      32'd7,         32'd14,        "divu");
    run_op(3'b111, 32'd100,      32'd7,         32'd2,         "remu");

    // Abort a DIV at its tenth iteration; nothing is queued, so any done is spurious.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.SrcA = 32'hFFFF_FFF9; bus.SrcB = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",   32'(bus.busy), 32'd0);
    check("abort_done",   32'(bus.done), 32'd0);
    check("abort_result", bus.Result,    32'd0);
    rst  = 1'b0;
    base = n_done;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(n_done), 32'(base));
    run_op(3'b000, 32'd3, 32'd4, 32'd12, "mul_after_rst");

    // Back-to-back: the second request is held during the DONE cycle of the first.
    @(negedge clk);
    issue(3'b000, 32'h1234, 32'h10, 32'h12340, "b2b_first");
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b2b_first");
    issue(3'b000, 32'd5, 32'd6, 32'd30, "b2b_second");
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy",     32'(bus.busy), 32'd1);
    check("b2b_done_low", 32'(bus.done), 32'd0);
    wait_done("b2b_second");

    // A start pulse in CALC must be ignored.
    @(negedge clk);
    issue(3'b101, 32'd1000, 32'd10, 32'd100, "ignore_mid");
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b000; bus.SrcA = 32'd3; bus.SrcB = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_mid");
    @(posedge clk);
    base = n_done;
    repeat (40) @(negedge clk);
    check("ignore_no_second", 32'(n_done), 32'(base));

    for (int i = 0; i < 20; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op(ro, ra, rb, ref_model(ro, ra, rb), "rand");
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(q_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
